apb_master_arb: RTL and testbench
=================================

Name: apb_master_arb

Overview:
- APB master that shares the single APB slave port (apb_dut) between NUM_REQ requesters.
- Round-robin arbitration across requesters; sequences IDLE/SETUP/ACCESS phases and waits on pready.
- Returns read data and error status to the winning requester.
- Optional access timeout protects against a slave that never asserts pready.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 32: paddr width.
- DATA_W, 32: pwdata/prdata width.
- TIMEOUT, 16: max ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock.
- presetn  in  1  reset; asynchronous, active-low (already decided).
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester command accept; at most one bit high.
- req_write  in  NUM_REQ  per-requester write(1)/read(0).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse, one-hot.
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts.
- rsp_err  out  1  pslverr or timeout, qualified by rsp_valid.
- timeout_evt  out  1  one-cycle pulse on timeout abort.
- busy  out  1  high in SETUP/ACCESS.
- psel, penable, pwrite  out  1 each  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  slave ready.
- pslverr  in  1  slave error.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- FSM states are IDLE, SETUP, ACCESS.
- IDLE:
  - Winner g is the first asserted req_valid, searching from pointer upward modulo NUM_REQ.
  - req_ready[g] = 1 combinationally in IDLE only. The handshake is req_valid[g] & req_ready[g].
  - On handshake: register addr, wdata and write into paddr/pwdata/pwrite; store g; pointer <= (g+1) mod NUM_REQ; go to SETUP.
- SETUP (one cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS:
  - psel=1, penable=1; timeout counter increments each cycle in ACCESS.
  - If pready: next cycle rsp_valid[g]=1, rsp_err=pslverr, rsp_rdata = pwrite ? 0 : prdata (sampled the cycle pready=1). psel/penable drop to 0 and the FSM returns to IDLE.
- Timeout:
  - Applies when TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0 (i.e. the TIMEOUT-th ACCESS cycle without pready).
  - Next cycle: psel=penable=0, rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, timeout_evt=1; FSM returns to IDLE.
  - A pready arriving on the same cycle as the timeout wins, so a normal completion is reported.
- Timing:
  - Handshake at cycle T → SETUP T+1 → ACCESS T+2 → with zero wait states, rsp_valid at T+3.
  - The next handshake is possible at T+3 (one IDLE cycle between transfers; psel low that cycle).
- paddr, pwrite and pwdata stay stable from SETUP until the cycle after completion.
- paddr, pwdata and pwrite retain their last values in IDLE; only psel and penable qualify them.
- A requester deasserting req_valid before its handshake is legal. The arbiter re-evaluates every IDLE cycle with no stickiness.
- rsp_valid, rsp_err and timeout_evt are single-cycle pulses with no backpressure.
- Reset mid-transaction: asynchronous clear to reset values. No response is issued for the in-flight command, and the pointer returns to 0.
- The stored grant index is $clog2(NUM_REQ) bits wide. The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates.

Decomposition:
- Package apb_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  - default ADDR_W/DATA_W localparams;
  - a function that extracts the slice for requester i from packed vectors.
- Sub-module apb_rr_arbiter (NUM_REQ): inputs req, pointer, enable; outputs one-hot grant and the grant index. It is combinational; the pointer register stays in the parent.

Test Plan:
- Single write from req0 (addr 0x10, data 0xA5A5_0001), pready tied 1 → psel at T+1, penable at T+2, rsp_valid[0] at T+3, rsp_err=0.
- req0 and req1 both hold valid for 4 transfers → grant order 0,1,0,1; never two req_ready bits high.
- Read from req1 at addr 0x20 with pready low for 3 ACCESS cycles, then prdata=0xDEAD_BEEF → paddr stable throughout; rsp_rdata=0xDEAD_BEEF, rsp_valid[1] one cycle after pready.
- pslverr=1 with pready → rsp_err=1 on the response; next transfer proceeds normally.
- TIMEOUT=16, pready held 0 → abort after 16 ACCESS cycles: timeout_evt=1, rsp_err=1, rsp_rdata=0, psel=0. Also drive pready=1 on cycle 16 → normal completion, no timeout_evt.
- presetn pulsed low during ACCESS → all outputs 0 immediately, no rsp_valid. The next request from req1 is granted only after req0 is absent, confirming the pointer was reset to 0.

Source files
------------

// File: rtl/apb_master_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM state encoding,
// default bus widths and a slice extractor for packed per-requester vectors.
package apb_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Widest packed request vector the helper accepts (8 requesters x 64 bits)
    localparam int MAX_REQ = 8;
    localparam int MAX_W   = 64;
    localparam int VEC_W   = MAX_REQ * MAX_W;

    function automatic logic [MAX_W-1:0] req_slice(input logic [VEC_W-1:0] vec,
                                                   input int unsigned     idx,
                                                   input int unsigned     w);
        logic [VEC_W-1:0] shifted;
        logic [MAX_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = '1;
        if (w < MAX_W) mask = (MAX_W'(1) << w) - MAX_W'(1);
        return shifted[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bus bundle between the arbitrating master and a single slave.
interface apb_master_arb_if
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_arb_rr.sv
// Combinational round-robin picker: first asserted request at or above the
// pointer, wrapping modulo NUM_REQ. The pointer register lives in the parent.
module apb_rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    always_comb begin
        logic found;
        int   j;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(pointer) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (enable && !found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by NUM_REQ requesters: round-robin grant in IDLE, then
// SETUP/ACCESS on the bus, with an optional abort when pready never comes.
module apb_master_arb
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      timeout_evt,
    output logic                      busy,
    apb_master_arb_if.master          apb
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    apb_state_e         state, state_d;
    logic [IW-1:0]      ptr, gidx_q, arb_idx;
    logic [NUM_REQ-1:0] arb_grant;
    logic [CW-1:0]      tcnt;
    logic               hs, timeout_hit;
    logic [VEC_W-1:0]   addr_vec, wdata_vec;

    assign addr_vec  = VEC_W'(req_addr);
    assign wdata_vec = VEC_W'(req_wdata);

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .pointer   (ptr),
        .enable    (state == IDLE),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready   = arb_grant;
    assign hs          = |(req_valid & arb_grant);
    assign apb.psel    = (state != IDLE);
    assign apb.penable = (state == ACCESS);
    assign busy        = (state != IDLE);
    // tcnt holds completed ACCESS cycles, so TLIM marks the TIMEOUT-th one; pready wins the tie
    assign timeout_hit = (TIMEOUT > 0) && (state == ACCESS) && !apb.pready && (tcnt == CW'(TLIM));

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (hs) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb.pready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx_q      <= '0;
            tcnt        <= '0;
            apb.paddr   <= '0;
            apb.pwdata  <= '0;
            apb.pwrite  <= 1'b0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            state       <= state_d;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            timeout_evt <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    apb.paddr  <= ADDR_W'(req_slice(addr_vec, 32'(arb_idx), ADDR_W));
                    apb.pwdata <= DATA_W'(req_slice(wdata_vec, 32'(arb_idx), DATA_W));
                    apb.pwrite <= req_write[arb_idx];
                    gidx_q     <= arb_idx;
                    ptr        <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end
                SETUP: tcnt <= '0;
                ACCESS: begin
                    if (apb.pready) begin
                        rsp_valid <= NUM_REQ'(1) << gidx_q;
                        rsp_err   <= apb.pslverr;
                        rsp_rdata <= apb.pwrite ? '0 : apb.prdata;
                        tcnt      <= '0;
                    end else if (timeout_hit) begin
                        rsp_valid   <= NUM_REQ'(1) << gidx_q;
                        rsp_err     <= 1'b1;
                        timeout_evt <= 1'b1;
                        tcnt        <= '0;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: table of single transfers plus
// hand-written timeout and mid-transfer reset sequences.
module tb_apb_master_arb;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             pclk = 1'b0;
    logic             presetn;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err, timeout_evt, busy;

    apb_master_arb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_master_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .timeout_evt (timeout_evt),
        .busy        (busy),
        .apb         (apb)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [1:0]  vmask;
        logic        wr;
        logic [31:0] a0, a1, d0, d1;
        int          waits;
        logic [31:0] prd;
        logic        serr;
        int          exp_g;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] vm, input logic wr, input logic [31:0] a0, a1, d0, d1,
                                input int waits, input logic [31:0] prd, input logic serr,
                                input int eg, input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.vmask = vm; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.waits = waits; v.prd = prd; v.serr = serr;
        v.exp_g = eg; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    task automatic step();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic set_req(input logic [1:0] vm, input logic wr, input logic [31:0] a0, a1, d0, d1);
        req_valid = vm;
        req_write = {wr, wr};
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
    endtask

    task automatic wait_hs(output int g, output bit ok);
        g  = -1;
        ok = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("ready_onehot", 64'($countones(req_ready) > 1), 64'd0);
            if (|(req_valid & req_ready)) begin
                g  = req_ready[1] ? 1 : 0;
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int          g;
        bit          ok;
        logic [31:0] ea, ed;
        set_req(v.vmask, v.wr, v.a0, v.a1, v.d0, v.d1);
        wait_hs(g, ok);
        chk($sformatf("v%0d_handshake", id), 64'(ok), 64'd1);
        if (!ok) begin
            req_valid = '0;
            return;
        end
        ea = (v.exp_g == 1) ? v.a1 : v.a0;
        ed = (v.exp_g == 1) ? v.d1 : v.d0;
        chk($sformatf("v%0d_grant", id), 64'(g), 64'(v.exp_g));
        chk($sformatf("v%0d_idle_psel", id), 64'(apb.psel), 64'd0);
        step();
        req_valid = '0;
        chk($sformatf("v%0d_setup_sel_en", id), 64'({apb.psel, apb.penable}), 64'(2'b10));
        chk($sformatf("v%0d_setup_paddr", id), 64'(apb.paddr), 64'(ea));
        chk($sformatf("v%0d_setup_pwrite", id), 64'(apb.pwrite), 64'(v.wr));
        if (v.wr) chk($sformatf("v%0d_setup_pwdata", id), 64'(apb.pwdata), 64'(ed));
        step();
        for (int w = 0; w < v.waits; w++) begin
            chk($sformatf("v%0d_wait_sel_en", id), 64'({apb.psel, apb.penable}), 64'(2'b11));
            chk($sformatf("v%0d_wait_paddr", id), 64'(apb.paddr), 64'(ea));
            chk($sformatf("v%0d_wait_rsp", id), 64'(rsp_valid), 64'd0);
            step();
        end
        apb.pready  = 1'b1;
        apb.prdata  = v.prd;
        apb.pslverr = v.serr;
        chk($sformatf("v%0d_access_sel_en", id), 64'({apb.psel, apb.penable}), 64'(2'b11));
        step();
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = 32'h0BAD_0BAD;
        chk($sformatf("v%0d_rsp_valid", id), 64'(rsp_valid), 64'(2'b01 << v.exp_g));
        chk($sformatf("v%0d_rsp_rdata", id), 64'(rsp_rdata), 64'(v.exp_rdata));
        chk($sformatf("v%0d_rsp_err", id), 64'(rsp_err), 64'(v.exp_err));
        chk($sformatf("v%0d_rsp_psel", id), 64'({apb.psel, apb.penable}), 64'd0);
        chk($sformatf("v%0d_rsp_timeout", id), 64'(timeout_evt), 64'd0);
        chk($sformatf("v%0d_rsp_paddr_hold", id), 64'(apb.paddr), 64'(ea));
    endtask

    // Handshake then advance to the first ACCESS cycle
    task automatic to_access(input string tag, input int exp_g);
        int g;
        bit ok;
        wait_hs(g, ok);
        chk({tag, "_handshake"}, 64'(ok), 64'd1);
        chk({tag, "_grant"}, 64'(g), 64'(exp_g));
        step();
        req_valid = '0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        presetn     = 1'b0;
        req_valid   = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        apb.prdata  = '0;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;

        tbl[0] = mk(2'b01, 1'b1, 32'h10,  32'h0,   32'hA5A5_0001, 32'h0,    0, 32'h0,         1'b0, 0, 32'h0,         1'b0);
        tbl[1] = mk(2'b10, 1'b0, 32'h0,   32'h20,  32'h0,         32'h0,    3, 32'hDEAD_BEEF, 1'b0, 1, 32'hDEAD_BEEF, 1'b0);
        tbl[2] = mk(2'b11, 1'b1, 32'h100, 32'h200, 32'h1111,      32'h2222, 0, 32'h0,         1'b0, 0, 32'h0,         1'b0);
        tbl[3] = mk(2'b11, 1'b1, 32'h104, 32'h204, 32'h3333,      32'h4444, 0, 32'h0,         1'b0, 1, 32'h0,         1'b0);
        tbl[4] = mk(2'b11, 1'b0, 32'h108, 32'h208, 32'h0,         32'h0,    1, 32'h33,        1'b0, 0, 32'h33,        1'b0);
        tbl[5] = mk(2'b11, 1'b0, 32'h10C, 32'h20C, 32'h0,         32'h0,    0, 32'h44,        1'b0, 1, 32'h44,        1'b0);
        tbl[6] = mk(2'b01, 1'b1, 32'h30,  32'h0,   32'h5A5A_0006, 32'h0,    0, 32'h77,        1'b1, 0, 32'h0,         1'b1);
        tbl[7] = mk(2'b10, 1'b0, 32'h0,   32'h34,  32'h0,         32'h0,    0, 32'hCAFE_0007, 1'b0, 1, 32'hCAFE_0007, 1'b0);

        step();
        step();
        chk("rst_psel_penable", 64'({apb.psel, apb.penable}), 64'd0);
        chk("rst_paddr", 64'(apb.paddr), 64'd0);
        chk("rst_pwdata_pwrite", 64'({apb.pwdata, apb.pwrite}), 64'd0);
        chk("rst_rsp", 64'({rsp_valid, rsp_err, timeout_evt, busy}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        presetn = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Timeout: requester 0, pready never arrives; pointer is 0 here
        apb.prdata = 32'h0000_0055;
        set_req(2'b01, 1'b0, 32'h40, 32'h0, 32'h0, 32'h0);
        to_access("to", 0);
        for (int c = 1; c <= TO; c++) begin
            chk($sformatf("to_access%0d_sel_en", c), 64'({apb.psel, apb.penable}), 64'(2'b11));
            chk($sformatf("to_access%0d_evt", c), 64'({timeout_evt, rsp_valid}), 64'd0);
            if (c < TO) step();
        end
        step();
        chk("to_evt", 64'(timeout_evt), 64'd1);
        chk("to_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("to_psel", 64'({apb.psel, apb.penable, busy}), 64'd0);
        step();
        chk("to_evt_pulse", 64'({timeout_evt, rsp_valid}), 64'd0);

        // pready on the 16th ACCESS cycle wins over the timeout; requester 1
        set_req(2'b10, 1'b0, 32'h0, 32'h44, 32'h0, 32'h0);
        to_access("tie", 1);
        for (int c = 1; c < TO; c++) step();
        apb.pready = 1'b1;
        apb.prdata = 32'h0000_600D;
        chk("tie_access16_sel_en", 64'({apb.psel, apb.penable}), 64'(2'b11));
        step();
        apb.pready = 1'b0;
        chk("tie_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("tie_rsp_err", 64'(rsp_err), 64'd0);
        chk("tie_no_timeout", 64'(timeout_evt), 64'd0);
        chk("tie_rsp_rdata", 64'(rsp_rdata), 64'h600D);

        // Reset in ACCESS after a req0 grant has moved the pointer to 1
        set_req(2'b01, 1'b1, 32'h50, 32'h0, 32'h1234_5678, 32'h0);
        to_access("rst", 0);
        chk("rst_pre_sel_en", 64'({apb.psel, apb.penable}), 64'(2'b11));
        presetn = 1'b0;
        #1;
        chk("rst_mid_sel_en", 64'({apb.psel, apb.penable, busy}), 64'd0);
        chk("rst_mid_bus", 64'({apb.paddr, apb.pwrite}), 64'd0);
        chk("rst_mid_rsp", 64'({rsp_valid, rsp_err, timeout_evt}), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk($sformatf("rst_after%0d_rsp", c), 64'({rsp_valid, apb.psel}), 64'd0);
        end
        set_req(2'b11, 1'b0, 32'h60, 32'h64, 32'h0, 32'h0);
        chk("rst_ptr_grant_both", 64'(req_ready), 64'(2'b01));
        req_valid = 2'b10;
        #1;
        chk("rst_ptr_grant_req1", 64'(req_ready), 64'(2'b10));
        step();
        req_valid = '0;
        chk("rst_req1_paddr", 64'(apb.paddr), 64'h64);
        step();
        apb.pready = 1'b1;
        apb.prdata = 32'h0000_0099;
        step();
        apb.pready = 1'b0;
        chk("rst_req1_rsp_valid", 64'(rsp_valid), 64'(2'b10));
        chk("rst_req1_rsp_rdata", 64'(rsp_rdata), 64'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
